// File: rtl/uart_dma_loader_if.sv
// uart_dma_loader bus: UART rx/tx side plus the
// DMA strobes and data word toward the memory hub.
interface uart_dma_loader_if;
  logic        rx_ready;
  logic [7:0]  rdata;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  sdata;
  logic        instr_ready;
  logic        mem_ready;
  logic [31:0] data;
  logic        program_loaded;

  modport master (
    input  rx_ready, rdata, tx_busy,
    output tx_start, sdata, instr_ready,
    output mem_ready, data, program_loaded
  );

  modport slave (
    output rx_ready, rdata, tx_busy,
    input  tx_start, sdata, instr_ready,
    input  mem_ready, data, program_loaded
  );
endinterface

// File: rtl/uart_dma_loader.sv
// UART boot loader / DMA front end: packs rx bytes
// into LE words. Option: UART_DMA_LOADER_BYTE_PASS_EN.
module uart_dma_loader #(
  parameter logic [7:0]  START_BYTE      = 8'h99,
  parameter logic [7:0]  ACK_BYTE        = 8'hAA,
  parameter int unsigned MAX_INSTR_WORDS = 256
) (
  input logic             clock,
  input logic             reset,
  uart_dma_loader_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, LEN, LOAD, ACK, ACK_WAIT, RUN
  } state_t;

  state_t      state;
  logic [1:0]  idx;
  logic [23:0] lanes;
  logic [31:0] remaining;
  logic [31:0] written;
  logic [31:0] word;
  logic        done;
  logic        pack;

  // byte 4 arrives straight from rdata, lanes 0-2 are held
  assign word = {bus.rdata, lanes};
  assign done = bus.rx_ready && (idx == 2'd3);

`ifdef UART_DMA_LOADER_BYTE_PASS_EN
  assign pack = (state == LEN) || (state == LOAD);
`else
  assign pack = (state == LEN) || (state == LOAD) ||
                (state == RUN);
`endif

  // boot FSM, byte packer and registered strobes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      idx                <= 2'd0;
      lanes              <= 24'd0;
      remaining          <= 32'd0;
      written            <= 32'd0;
      bus.tx_start       <= 1'b0;
      bus.sdata          <= 8'd0;
      bus.instr_ready    <= 1'b0;
      bus.mem_ready      <= 1'b0;
      bus.data           <= 32'd0;
      bus.program_loaded <= 1'b0;
    end else begin
      bus.instr_ready <= 1'b0;
      bus.mem_ready   <= 1'b0;
      bus.tx_start    <= 1'b0;

      if (pack && bus.rx_ready) begin
        idx <= idx + 2'd1;
        unique case (idx)
          2'd0: lanes[7:0]   <= bus.rdata;
          2'd1: lanes[15:8]  <= bus.rdata;
          2'd2: lanes[23:16] <= bus.rdata;
          default: ;
        endcase
      end

      unique case (state)
        IDLE: begin
          if (bus.rx_ready && bus.rdata == START_BYTE) begin
            state <= LEN;
            idx   <= 2'd0;
          end
        end
        LEN: begin
          if (done) begin
            bus.data <= word;
            if (word == 32'd0) begin
              state <= ACK;
            end else begin
              remaining <= word;
              state     <= LOAD;
            end
          end
        end
        LOAD: begin
          if (done) begin
            bus.data  <= word;
            remaining <= remaining - 32'd1;
            if (written < 32'(MAX_INSTR_WORDS)) begin
              bus.instr_ready <= 1'b1;
              written         <= written + 32'd1;
            end
            if (remaining == 32'd1) state <= ACK;
          end
        end
        ACK: begin
          if (!bus.tx_busy) begin
            bus.sdata    <= ACK_BYTE;
            bus.tx_start <= 1'b1;
            state        <= ACK_WAIT;
          end
        end
        ACK_WAIT: begin
          state              <= RUN;
          bus.program_loaded <= 1'b1;
        end
        RUN: begin
`ifdef UART_DMA_LOADER_BYTE_PASS_EN
          if (bus.rx_ready) begin
            bus.data      <= {24'd0, bus.rdata};
            bus.mem_ready <= 1'b1;
          end
`else
          if (done) begin
            bus.data      <= word;
            bus.mem_ready <= 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_dma_loader.sv
// Scoreboard bench for uart_dma_loader: boot, ack
// backpressure, overflow load, RUN streaming, reset.
module tb_uart_dma_loader;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] val;
  } exp_t;

  localparam logic [1:0] K_INSTR = 2'd0;
  localparam logic [1:0] K_MEM   = 2'd1;
  localparam logic [1:0] K_ACK   = 2'd2;

  logic clock;
  logic reset;
  uart_dma_loader_if bus();

  uart_dma_loader dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sbq[$];
  int n_vec = 0;
  int n_err = 0;
  int instr_cnt = 0;
  int mem_cnt = 0;
  int ack_cnt = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // monitor: pop one expectation per observed strobe
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.instr_ready || bus.mem_ready ||
          bus.tx_start) begin
        logic [1:0]  k;
        logic [31:0] v;
        exp_t e;
        chk("excl", 64'(bus.instr_ready & bus.mem_ready),
            64'd0);
        if (bus.tx_start) begin
          k = K_ACK;
          v = {24'd0, bus.sdata};
          ack_cnt++;
        end else if (bus.instr_ready) begin
          k = K_INSTR;
          v = bus.data;
          instr_cnt++;
        end else begin
          k = K_MEM;
          v = bus.data;
          mem_cnt++;
        end
        if (sbq.size() == 0) begin
          chk("unexpected", 64'(k), 64'd3);
        end else begin
          e = sbq.pop_front();
          chk("kind", 64'(k), 64'(e.kind));
          chk("value", 64'(v), 64'(e.val));
        end
      end
    end
  end

  task automatic push(input logic [1:0] k,
                      input logic [31:0] v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    sbq.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock);
    #1;
    bus.rx_ready = 1'b1;
    bus.rdata    = b;
    @(posedge clock);
    #1;
    bus.rx_ready = 1'b0;
  endtask

  // four bytes, little-endian, on consecutive cycles
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) @(posedge clock);
      #1;
      bus.rx_ready = 1'b1;
      bus.rdata    = w[8*i +: 8];
      @(posedge clock);
    end
    #1;
    bus.rx_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {21'd0, bus.tx_start, bus.sdata,
              bus.instr_ready, bus.mem_ready,
              bus.data, bus.program_loaded}, 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk_zero("reset_outs");
    idle(3);
    reset = 1'b0;
    idle(2);
  endtask

  task automatic push_run_word(input logic [31:0] w);
`ifdef UART_DMA_LOADER_BYTE_PASS_EN
    for (int i = 0; i < 4; i++)
      push(K_MEM, {24'd0, w[8*i +: 8]});
`else
    push(K_MEM, w);
`endif
  endtask

  int b_i, b_m, b_a;

  task automatic snap();
    b_i = instr_cnt;
    b_m = mem_cnt;
    b_a = ack_cnt;
  endtask

  initial begin
    reset = 1'b1;
    bus.rx_ready = 1'b0;
    bus.rdata    = 8'd0;
    bus.tx_busy  = 1'b0;
    idle(2);
    do_reset();

    // basic two-word boot
    snap();
    push(K_INSTR, 32'h44332211);
    push(K_INSTR, 32'h88776655);
    push(K_ACK, 32'h000000AA);
    send_byte(8'h99);
    send_word(32'd2);
    send_word(32'h44332211);
    idle(3);
    send_word(32'h88776655);
    idle(10);
    chk("t1_sb", 64'(sbq.size()), 64'd0);
    chk("t1_instr", 64'(instr_cnt - b_i), 64'd2);
    chk("t1_ack", 64'(ack_cnt - b_a), 64'd1);
    chk("t1_loaded", 64'(bus.program_loaded), 64'd1);
    chk("t1_sdata", 64'(bus.sdata), 64'hAA);

    // RUN streaming, START_BYTE not special
    snap();
    push_run_word(32'hEFBEADDE);
    send_word(32'hEFBEADDE);
    idle(4);
    push_run_word(32'h00000099);
    send_word(32'h00000099);
    idle(4);
    chk("t2_sb", 64'(sbq.size()), 64'd0);
    chk("t2_instr", 64'(instr_cnt - b_i), 64'd0);
`ifdef UART_DMA_LOADER_BYTE_PASS_EN
    chk("t2_mem", 64'(mem_cnt - b_m), 64'd8);
`else
    chk("t2_mem", 64'(mem_cnt - b_m), 64'd2);
`endif
    chk("t2_ack", 64'(ack_cnt - b_a), 64'd0);

    // N=0 boot with transmitter held busy
    do_reset();
    snap();
    bus.tx_busy = 1'b1;
    push(K_ACK, 32'h000000AA);
    send_byte(8'h99);
    send_word(32'd0);
    idle(50);
    chk("t3_busy_ack", 64'(ack_cnt - b_a), 64'd0);
    chk("t3_busy_loaded", 64'(bus.program_loaded),
        64'd0);
    bus.tx_busy = 1'b0;
    idle(10);
    chk("t3_ack", 64'(ack_cnt - b_a), 64'd1);
    chk("t3_instr", 64'(instr_cnt - b_i), 64'd0);
    chk("t3_loaded", 64'(bus.program_loaded), 64'd1);
    chk("t3_sb", 64'(sbq.size()), 64'd0);

    // garbage then N=258, only 256 written
    do_reset();
    snap();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    send_byte(8'h99);
    send_word(32'd258);
    for (int i = 0; i < 257; i++) begin
      if (i < 256) push(K_INSTR, 32'hC0DE0000 + i);
      send_word(32'hC0DE0000 + i);
    end
    idle(6);
    chk("t4_early_ack", 64'(ack_cnt - b_a), 64'd0);
    chk("t4_instr", 64'(instr_cnt - b_i), 64'd256);
    push(K_ACK, 32'h000000AA);
    send_word(32'hC0DE0101);
    idle(8);
    chk("t4_ack", 64'(ack_cnt - b_a), 64'd1);
    chk("t4_instr_end", 64'(instr_cnt - b_i),
        64'd256);
    chk("t4_loaded", 64'(bus.program_loaded), 64'd1);
    chk("t4_sb", 64'(sbq.size()), 64'd0);

    // reset in the middle of an instruction word
    do_reset();
    push(K_INSTR, 32'h0BADF00D);
    send_byte(8'h99);
    send_word(32'd2);
    send_word(32'h0BADF00D);
    send_byte(8'h01);
    send_byte(8'h02);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("t5_async_rst");
    idle(3);
    reset = 1'b0;
    idle(2);
    snap();
    push(K_INSTR, 32'h13572468);
    push(K_ACK, 32'h000000AA);
    send_byte(8'h99);
    send_word(32'd1);
    send_word(32'h13572468);
    idle(8);
    chk("t5_instr", 64'(instr_cnt - b_i), 64'd1);
    chk("t5_ack", 64'(ack_cnt - b_a), 64'd1);
    chk("t5_loaded", 64'(bus.program_loaded), 64'd1);
    chk("t5_sb", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_dma_loader.md
Name: uart_dma_loader

Overview:
- Receive-side DMA front end that feeds the memory controller hub's DMA inputs (instr_ready, mem_ready, data).
- Assembles bytes from the UART receiver into 32-bit little-endian words.
- Runs the boot protocol: start byte, word count, instruction stream, then an ack byte on the shared UART transmitter.
- After boot, streams every further received word into the input-data ring buffer as mem_ready pulses.

Parameters:
- START_BYTE, 8'h99, byte that opens a program download.
- ACK_BYTE, 8'hAA, byte transmitted once the program is fully loaded.
- MAX_INSTR_WORDS, 256, instruction words actually written (code segment capacity); excess words are consumed but not written.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rx_ready  input  1  one-cycle pulse: rdata holds a new received byte.
- rdata  input  8  received byte.
- tx_busy  input  1  UART transmitter busy.
- tx_start  output  1  one-cycle pulse: start transmitting sdata.
- sdata  output  8  byte to transmit.
- instr_ready  output  1  one-cycle pulse: data is the next instruction word.
- mem_ready  output  1  one-cycle pulse: data is the next input-data word.
- data  output  32  assembled word.
- program_loaded  output  1  high once the ack has been issued; stays high until reset.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-word or mid-load):
  - All outputs go to 0; state = IDLE; byte index = 0; counters = 0.
- Byte assembly:
  - Each rx_ready places rdata into byte lane idx (lane 0 = bits 7:0, first received), then idx = (idx+1) mod 4.
  - On the 4th byte the word is complete; the data register loads it in that same edge.
  - The strobe is registered: it is high during the cycle after the rx_ready cycle of byte 4.
  - data holds its value until the next word completes.
  - rx_ready is ignored in ACK and ACK_WAIT.
- States:
  - IDLE: rx_ready with rdata==START_BYTE -> LEN (idx cleared). Any other byte is discarded.
  - LEN: assemble one word N (32-bit unsigned). No strobe. N==0 -> ACK, otherwise -> LOAD with remaining=N.
  - LOAD: each completed word pulses instr_ready for 1 cycle if fewer than MAX_INSTR_WORDS words have been written; otherwise no pulse. remaining decrements per word; remaining reaching 0 -> ACK.
  - ACK: wait for tx_busy==0, then sdata<=ACK_BYTE and tx_start<=1 for exactly one cycle -> ACK_WAIT.
  - ACK_WAIT: one cycle, so tx_busy can assert -> RUN; program_loaded<=1 on entry to RUN.
  - RUN: each completed word pulses mem_ready for 1 cycle. Stays in RUN until reset; START_BYTE has no special meaning here.
- Strobe rules:
  - instr_ready and mem_ready are never high together.
  - At most one strobe per 4 rx_ready pulses.
  - Back-to-back rx_ready on consecutive cycles must be accepted with no byte lost.
- Width and arithmetic:
  - remaining and written-count are 32-bit and do not wrap.
  - N up to 2^32-1 is accepted; only the first MAX_INSTR_WORDS words are written.
- tx_start is only ever driven in ACK; sdata keeps ACK_BYTE afterwards.

Optional Feature:
- UART_DMA_LOADER_BYTE_PASS_EN defined:
  - In RUN, every received byte produces a mem_ready pulse the next cycle with data = {24'b0, rdata}.
  - No 4-byte packing in RUN.
  - IDLE, LEN and LOAD still pack words.
- Not defined:
  - RUN packs 4 bytes per word as specified above.

Test Plan:
- Reset then bytes 99 02 00 00 00, 11 22 33 44, 55 66 77 88 -> instr_ready pulses twice with data 0x44332211 then 0x88776655; then tx_start pulses once with sdata=0xAA; program_loaded=1.
- Boot with N=0 (99 00 00 00 00) -> no instr_ready; ack sent; program_loaded=1.
- Hold tx_busy=1 for 50 cycles at ack time -> tx_start stays 0 until tx_busy falls, then exactly one pulse.
- In RUN send DE AD BE EF with rx_ready on 4 consecutive cycles -> exactly one mem_ready pulse, data=0xEFBEADDE; no instr_ready.
- Garbage bytes 00 FF 12 before 99 in IDLE -> ignored; the subsequent load is correct. N=258 with MAX_INSTR_WORDS=256 -> 256 instr_ready pulses, ack after word 258.
- Assert reset after 2 bytes of an instruction word -> all outputs 0 immediately; a new full boot sequence then succeeds from IDLE.
